// File: rtl/timer_multi.sv
//============================================================================
// Module   : timer_multi
// Purpose  : N_CH independent CNT_W-bit up-counters sharing one programmable
//            prescaler. Each channel runs in periodic (auto-reload) or
//            one-shot mode against its own compare period, and has a sticky
//            interrupt flag with clear and a snapshot (sample) register.
// Ports    : clk                     system clock
//            rst                     asynchronous reset, active-low
//            TIMER_ENABLE[N]         channel runs while 1
//            TIMER_MODE[N]           0 = periodic, 1 = one-shot
//            TIMER_RESET[N]          synchronous counter clear pulse
//            TIMER_PERIOD[N*W]       compare value, slice [i*W +: W]
//            TIMER_PRESCALE[P]       tick every PRESCALE+1 clk cycles
//            TIMER_SAMPLE[N]         capture counter into TIMER_VALUE
//            TIMER_INTERRUPT_ENABLE  arm flag setting per channel
//            TIMER_INTERRUPT_CLEAR   clear pending flag pulse per channel
//            TIMER_VALUE[N*W]        sampled counter value per channel
//            TIMER_INTERRUPT[N]      sticky pending flag per channel
//            TIMER_IRQ               OR of all pending flags (registered)
//            TIMER_RUNNING[N]        channel actively counting
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module timer_multi #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         TIMER_ENABLE,
    input  logic [N_CH-1:0]         TIMER_MODE,
    input  logic [N_CH-1:0]         TIMER_RESET,
    input  logic [N_CH*CNT_W-1:0]   TIMER_PERIOD,
    input  logic [PRESC_W-1:0]      TIMER_PRESCALE,
    input  logic [N_CH-1:0]         TIMER_SAMPLE,
    input  logic [N_CH-1:0]         TIMER_INTERRUPT_ENABLE,
    input  logic [N_CH-1:0]         TIMER_INTERRUPT_CLEAR,
    output logic [N_CH*CNT_W-1:0]   TIMER_VALUE,
    output logic [N_CH-1:0]         TIMER_INTERRUPT,
    output logic                    TIMER_IRQ,
    output logic [N_CH-1:0]         TIMER_RUNNING
);

    //------------------------------------------------------------------
    // Shared prescaler. The >= compare means that lowering PRESCALE below
    // the current count produces a tick straight away instead of waiting
    // for the counter to wrap.
    //------------------------------------------------------------------
    logic [PRESC_W-1:0] r_presc_cnt;
    logic               w_tick;

    assign w_tick = (r_presc_cnt >= TIMER_PRESCALE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc_cnt <= '0;
        end else if (w_tick) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + 1'b1;
        end
    end

    //------------------------------------------------------------------
    // Per-channel counters
    //------------------------------------------------------------------
    logic [N_CH-1:0] r_int;
    logic [N_CH-1:0] w_int_next;
    logic            r_irq;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_val;
            logic [CNT_W-1:0] w_period;
            logic             r_done;
            logic             w_run;
            logic             w_match;
            logic             w_event;

            assign w_period = TIMER_PERIOD[i*CNT_W +: CNT_W];
            assign w_run    = TIMER_ENABLE[i] & ~r_done;
            // >= so a period lowered below the live count fires on the next
            // tick rather than running all the way round 2^CNT_W.
            assign w_match  = (r_cnt >= w_period);
            // A counter clear has priority, so it also suppresses the event.
            assign w_event  = ~TIMER_RESET[i] & w_run & w_tick & w_match;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt  <= '0;
                    r_done <= 1'b0;
                end else if (TIMER_RESET[i]) begin
                    r_cnt  <= '0;
                    r_done <= 1'b0;
                end else if (!TIMER_ENABLE[i]) begin
                    // Count is held so re-enabling resumes where it stopped.
                    r_done <= 1'b0;
                end else if (w_run && w_tick) begin
                    if (w_match) begin
                        if (TIMER_MODE[i]) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cnt  <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // Snapshot takes the pre-update count, including on a clear pulse.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_val <= '0;
                end else if (TIMER_SAMPLE[i]) begin
                    r_val <= r_cnt;
                end
            end

            // Set beats clear; disarming does not drop a pending flag.
            assign w_int_next[i] = (w_event & TIMER_INTERRUPT_ENABLE[i]) |
                                   (r_int[i] & ~TIMER_INTERRUPT_CLEAR[i]);

            assign TIMER_RUNNING[i]                = w_run;
            assign TIMER_VALUE[i*CNT_W +: CNT_W]   = r_val;
        end
    endgenerate

    // IRQ is built from next-state flags so it lines up with TIMER_INTERRUPT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_int <= '0;
            r_irq <= 1'b0;
        end else begin
            r_int <= w_int_next;
            r_irq <= |w_int_next;
        end
    end

    assign TIMER_INTERRUPT = r_int;
    assign TIMER_IRQ       = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_timer_multi.sv
//============================================================================
// Module   : tb_timer_multi
// Purpose  : Directed self-checking bench for timer_multi (4 channels,
//            16-bit counters, 8-bit prescaler). Inputs change 1 time unit
//            after a rising edge; outputs are checked at the same point.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_timer_multi;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 16;
    localparam int PRESC_W = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       TIMER_ENABLE;
    logic [N_CH-1:0]       TIMER_MODE;
    logic [N_CH-1:0]       TIMER_RESET;
    logic [N_CH*CNT_W-1:0] TIMER_PERIOD;
    logic [PRESC_W-1:0]    TIMER_PRESCALE;
    logic [N_CH-1:0]       TIMER_SAMPLE;
    logic [N_CH-1:0]       TIMER_INTERRUPT_ENABLE;
    logic [N_CH-1:0]       TIMER_INTERRUPT_CLEAR;
    logic [N_CH*CNT_W-1:0] TIMER_VALUE;
    logic [N_CH-1:0]       TIMER_INTERRUPT;
    logic                  TIMER_IRQ;
    logic [N_CH-1:0]       TIMER_RUNNING;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    timer_multi #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .TIMER_ENABLE           (TIMER_ENABLE),
        .TIMER_MODE             (TIMER_MODE),
        .TIMER_RESET            (TIMER_RESET),
        .TIMER_PERIOD           (TIMER_PERIOD),
        .TIMER_PRESCALE         (TIMER_PRESCALE),
        .TIMER_SAMPLE           (TIMER_SAMPLE),
        .TIMER_INTERRUPT_ENABLE (TIMER_INTERRUPT_ENABLE),
        .TIMER_INTERRUPT_CLEAR  (TIMER_INTERRUPT_CLEAR),
        .TIMER_VALUE            (TIMER_VALUE),
        .TIMER_INTERRUPT        (TIMER_INTERRUPT),
        .TIMER_IRQ              (TIMER_IRQ),
        .TIMER_RUNNING          (TIMER_RUNNING)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] val(input int ch);
        return TIMER_VALUE[ch*CNT_W +: CNT_W];
    endfunction

    task automatic set_period(input int ch, input logic [CNT_W-1:0] p);
        TIMER_PERIOD[ch*CNT_W +: CNT_W] = p;
    endtask

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst                    = 1'b0;
        TIMER_ENABLE           = '0;
        TIMER_MODE             = '0;
        TIMER_RESET            = '0;
        TIMER_PERIOD           = '0;
        TIMER_PRESCALE         = '0;
        TIMER_SAMPLE           = '0;
        TIMER_INTERRUPT_ENABLE = '0;
        TIMER_INTERRUPT_CLEAR  = '0;

        // ---------------- reset state ----------------
        cyc(2);
        check("rst_value",   64'(TIMER_VALUE),     64'h0);
        check("rst_int",     64'(TIMER_INTERRUPT), 64'h0);
        check("rst_irq",     64'(TIMER_IRQ),       64'h0);
        check("rst_running", 64'(TIMER_RUNNING),   64'h0);
        rst = 1'b1;

        // ---------------- ch0 periodic, PERIOD=4, tick every clk ----------------
        TIMER_PRESCALE            = 8'd0;
        set_period(0, 16'd4);
        TIMER_INTERRUPT_ENABLE[0] = 1'b1;
        TIMER_ENABLE[0]           = 1'b1;
        cyc(4);                                  // cnt 0->1->2->3->4
        check("p0_running", 64'(TIMER_RUNNING[0]),   64'h1);
        check("p0_int_pre", 64'(TIMER_INTERRUPT[0]), 64'h0);
        TIMER_SAMPLE[0] = 1'b1;
        cyc(1);                                  // cnt=4 matches -> 0
        check("p0_val4",    64'(val(0)),             64'd4);
        check("p0_int",     64'(TIMER_INTERRUPT[0]), 64'h1);
        check("p0_irq",     64'(TIMER_IRQ),          64'h1);
        cyc(1);                                  // cnt 0 -> 1
        check("p0_wrap0",   64'(val(0)),             64'd0);
        TIMER_SAMPLE[0] = 1'b0;
        TIMER_ENABLE[0] = 1'b0;
        cyc(1);
        check("p0_sticky",  64'(TIMER_INTERRUPT[0]), 64'h1);

        // ---------------- event and clear in the same cycle ----------------
        set_period(0, 16'd0);                    // event on every tick
        TIMER_ENABLE[0]          = 1'b1;
        TIMER_INTERRUPT_CLEAR[0] = 1'b1;
        cyc(1);
        check("clr_set_wins", 64'(TIMER_INTERRUPT[0]), 64'h1);
        TIMER_ENABLE[0] = 1'b0;
        cyc(1);
        check("clr_alone_int", 64'(TIMER_INTERRUPT[0]), 64'h0);
        check("clr_alone_irq", 64'(TIMER_IRQ),          64'h0);
        TIMER_INTERRUPT_CLEAR[0] = 1'b0;

        // ---------------- ch1 one-shot, PRESCALE=2, PERIOD=3 ----------------
        TIMER_PRESCALE            = 8'd2;
        set_period(1, 16'd3);
        TIMER_MODE[1]             = 1'b1;
        TIMER_INTERRUPT_ENABLE[1] = 1'b1;
        TIMER_ENABLE[1]           = 1'b1;
        cyc(3);                                  // tick on 3rd edge: cnt 0->1
        TIMER_SAMPLE[1] = 1'b1;
        cyc(1);
        check("os_cnt1",     64'(val(1)),             64'd1);
        TIMER_SAMPLE[1] = 1'b0;
        cyc(7);                                  // ticks at edges 6, 9 -> cnt 3
        check("os_run_pre",  64'(TIMER_RUNNING[1]),   64'h1);
        cyc(1);                                  // edge 12: match, done
        check("os_run_done", 64'(TIMER_RUNNING[1]),   64'h0);
        check("os_int",      64'(TIMER_INTERRUPT[1]), 64'h1);
        TIMER_SAMPLE[1] = 1'b1;
        cyc(4);                                  // includes a tick; cnt holds
        check("os_hold3",    64'(val(1)),             64'd3);
        TIMER_SAMPLE[1] = 1'b0;
        TIMER_RESET[1]  = 1'b1;
        cyc(1);
        TIMER_RESET[1]  = 1'b0;
        check("os_rst_run",  64'(TIMER_RUNNING[1]),   64'h1);
        TIMER_SAMPLE[1] = 1'b1;
        cyc(1);
        check("os_rst_cnt",  64'(val(1)),             64'd0);
        TIMER_SAMPLE[1]          = 1'b0;
        TIMER_ENABLE[1]          = 1'b0;
        TIMER_INTERRUPT_CLEAR[1] = 1'b1;
        cyc(1);
        TIMER_INTERRUPT_CLEAR[1] = 1'b0;
        check("os_clr_irq",  64'(TIMER_IRQ),          64'h0);

        // ---------------- ch2 sample during a tick ----------------
        TIMER_PRESCALE  = 8'd0;
        set_period(2, 16'd100);
        TIMER_ENABLE[2] = 1'b1;
        cyc(7);                                  // cnt = 7
        TIMER_SAMPLE[2] = 1'b1;
        cyc(1);                                  // captures 7, cnt -> 8
        check("smp_pre",     64'(val(2)), 64'd7);
        TIMER_SAMPLE[2] = 1'b0;
        cyc(2);
        check("smp_hold",    64'(val(2)), 64'd7);
        TIMER_SAMPLE[2] = 1'b1;
        cyc(1);
        check("smp_update",  64'(val(2)), 64'd10);
        TIMER_SAMPLE[2] = 1'b0;
        TIMER_ENABLE[2] = 1'b0;

        // ---------------- ch3 period lowered below count ----------------
        set_period(3, 16'd20);
        TIMER_INTERRUPT_ENABLE[3] = 1'b1;
        TIMER_ENABLE[3]           = 1'b1;
        cyc(10);                                 // cnt = 10
        check("low_int_pre", 64'(TIMER_INTERRUPT[3]), 64'h0);
        set_period(3, 16'd5);
        cyc(1);
        check("low_int",     64'(TIMER_INTERRUPT[3]), 64'h1);
        check("low_irq",     64'(TIMER_IRQ),          64'h1);
        TIMER_SAMPLE[3] = 1'b1;
        cyc(1);
        check("low_cnt0",    64'(val(3)),             64'd0);
        TIMER_SAMPLE[3] = 1'b0;

        // ---------------- asynchronous reset mid-cycle ----------------
        #3;
        rst = 1'b0;
        #1;
        check("arst_value",  64'(TIMER_VALUE),     64'h0);
        check("arst_int",    64'(TIMER_INTERRUPT), 64'h0);
        check("arst_irq",    64'(TIMER_IRQ),       64'h0);
        check("arst_run",    64'(TIMER_RUNNING),   64'b1000);
        cyc(1);
        TIMER_PRESCALE  = 8'd1;
        TIMER_SAMPLE[3] = 1'b1;
        rst             = 1'b1;
        cyc(1);                                  // presc 0 -> 1, no tick
        cyc(1);                                  // tick: cnt 0 -> 1, sampled 0
        check("arst_cnt0",   64'(val(3)), 64'd0);
        cyc(1);                                  // no tick, sampled 1
        check("arst_cnt1",   64'(val(3)), 64'd1);
        TIMER_SAMPLE[3] = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
